cnt_ctrl: RTL and testbench

Register-mapped controller on the host side of the multi-channel counter array. It drives each counter channel's en/ld/val inputs from CPU register writes. It receives each channel's int output and latches it into sticky, maskable status. It combines the unmasked status into one registered irq line to the CPU.

---
 rtl/cnt_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cnt_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_ctrl
//  Purpose  : Host-side register block for a multi-channel counter array.
//             CPU writes drive each channel's enable, compare value and
//             one-cycle load pulse. Each channel's int level is captured
//             into sticky W1C status with an overrun flag, and the masked
//             status is reduced into a single registered interrupt.
//
//  Ports    : clk    - system clock, rising edge
//             xrst   - asynchronous active-low reset
//             wr     - register write strobe (one cycle per access)
//             rd     - register read strobe (one cycle per access)
//             addr   - register address [3:0]
//             wdata  - write data [7:0]
//             rdata  - registered read data [7:0]
//             en_o   - per-channel counter enable [CH-1:0]
//             ld_o   - per-channel one-cycle load pulse [CH-1:0]
//             val_o  - per-channel compare values, channel i at [i*VW +: VW]
//             int_i  - per-channel match level, sampled every clk [CH-1:0]
//             irq    - registered interrupt to the CPU
//
//  Register map (bits [7:CH] read 0, writes to them ignored)
//             0x0 CTRL  RW   channel enables
//             0x1 STAT  W1C  sticky int status
//             0x2 MASK  RW   irq enables
//             0x3 OVR   W1C  sticky overrun status
//             0x4+i VAL_i    compare value of channel i, write loads it
//
//  Revision : 1.0 - initial release
// ============================================================================
module cnt_ctrl #(
   parameter int CH = 4,   // number of counter channels, 1..8
   parameter int VW = 8    // compare value width
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic             wr,
   input  logic             rd,
   input  logic [3:0]       addr,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata,
   output logic [CH-1:0]    en_o,
   output logic [CH-1:0]    ld_o,
   output logic [CH*VW-1:0] val_o,
   input  logic [CH-1:0]    int_i,
   output logic             irq
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [3:0] c_ADDR_CTRL = 4'h0;
   localparam logic [3:0] c_ADDR_STAT = 4'h1;
   localparam logic [3:0] c_ADDR_MASK = 4'h2;
   localparam logic [3:0] c_ADDR_OVR  = 4'h3;
   localparam logic [3:0] c_ADDR_VAL0 = 4'h4;

   // Number of compare-value bits that travel over the 8-bit data bus.
   localparam int c_RW_BITS = (VW < 8) ? VW : 8;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [CH-1:0] ctrl_q, ctrl_d;
   logic [CH-1:0] stat_q, stat_d;
   logic [CH-1:0] mask_q, mask_d;
   logic [CH-1:0] ovr_q,  ovr_d;
   logic [CH-1:0] ld_q;
   logic [VW-1:0] val_q [CH];
   logic [7:0]    rdata_q, rdata_d;
   logic          irq_q, irq_d;

   // -------------------------------------------------------------------------
   // Write decode
   // -------------------------------------------------------------------------
   logic          w_wr_ctrl;
   logic          w_wr_stat;
   logic          w_wr_mask;
   logic          w_wr_ovr;
   logic [CH-1:0] w_wr_val;
   logic [CH-1:0] w_wdata_ch;
   logic [CH-1:0] w_stat_clr;
   logic [CH-1:0] w_ovr_clr;
   logic [CH-1:0] w_ovr_set;
   logic [VW-1:0] w_val_wr;
   logic [7:0]    w_rd_word;

   assign w_wr_ctrl  = wr && (addr == c_ADDR_CTRL);
   assign w_wr_stat  = wr && (addr == c_ADDR_STAT);
   assign w_wr_mask  = wr && (addr == c_ADDR_MASK);
   assign w_wr_ovr   = wr && (addr == c_ADDR_OVR);
   assign w_wdata_ch = wdata[CH-1:0];

   // Addresses 0x4+CH..0xF match no channel, so they neither write nor load.
   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         assign w_wr_val[gi]           = wr && (addr == (c_ADDR_VAL0 + 4'(gi)));
         assign val_o[gi*VW +: VW]     = val_q[gi];
      end
   endgenerate

   // Bus data is zero-extended (or truncated) to the compare value width.
   always_comb begin
      w_val_wr                  = '0;
      w_val_wr[c_RW_BITS-1:0]   = wdata[c_RW_BITS-1:0];
   end

   // -------------------------------------------------------------------------
   // Status / overrun next state
   // -------------------------------------------------------------------------
   assign w_stat_clr = w_wr_stat ? w_wdata_ch : '0;
   assign w_ovr_clr  = w_wr_ovr  ? w_wdata_ch : '0;

   // An overrun is a new int arriving on a bit that is still pending and is
   // not being acknowledged in this same cycle.
   assign w_ovr_set  = int_i & stat_q & ~w_stat_clr;

   always_comb begin
      ctrl_d = w_wr_ctrl ? w_wdata_ch : ctrl_q;
      mask_d = w_wr_mask ? w_wdata_ch : mask_q;
      // OR-ing the set after the clear makes a simultaneous set win.
      stat_d = (stat_q & ~w_stat_clr) | int_i;
      ovr_d  = (ovr_q  & ~w_ovr_clr)  | w_ovr_set;
      // Built from the current registers, so irq trails STAT/MASK by a cycle.
      irq_d  = |(stat_q & mask_q);
   end

   // -------------------------------------------------------------------------
   // Read mux: uses pre-write register values, so a same-cycle write is not
   // visible in the returned data.
   // -------------------------------------------------------------------------
   always_comb begin
      w_rd_word = '0;
      case (addr)
         c_ADDR_CTRL: w_rd_word[CH-1:0] = ctrl_q;
         c_ADDR_STAT: w_rd_word[CH-1:0] = stat_q;
         c_ADDR_MASK: w_rd_word[CH-1:0] = mask_q;
         c_ADDR_OVR:  w_rd_word[CH-1:0] = ovr_q;
         default: begin
            for (int i = 0; i < CH; i++) begin
               if (addr == (c_ADDR_VAL0 + 4'(i))) begin
                  w_rd_word[c_RW_BITS-1:0] = val_q[i][c_RW_BITS-1:0];
               end
            end
         end
      endcase
      rdata_d = rd ? w_rd_word : rdata_q;
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         ctrl_q  <= '0;
         stat_q  <= '0;
         mask_q  <= '0;
         ovr_q   <= '0;
         ld_q    <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            val_q[i] <= '0;
         end
      end else begin
         ctrl_q  <= ctrl_d;
         stat_q  <= stat_d;
         mask_q  <= mask_d;
         ovr_q   <= ovr_d;
         // A load pulse lasts exactly the cycle after each VAL write, so
         // back-to-back writes give contiguous pulses.
         ld_q    <= w_wr_val;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
         for (int i = 0; i < CH; i++) begin
            if (w_wr_val[i]) begin
               val_q[i] <= w_val_wr;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign en_o  = ctrl_q;
   assign ld_o  = ld_q;
   assign rdata = rdata_q;
   assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnt_ctrl
//  Purpose  : Self-checking bench for cnt_ctrl. A register-level model of the
//             block's rules is compared against the DUT outputs on every
//             falling edge; directed sequences add literal expectations.
//             A tiny counter for channel 0 closes the loop en/ld/val -> int.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_ctrl;
   localparam int CH = 4;
   localparam int VW = 8;
   localparam logic [7:0] CHM = 8'((1 << CH) - 1);

   logic            clk = 1'b0;
   logic            xrst = 1'b0;
   logic            wr = 1'b0;
   logic            rd = 1'b0;
   logic [3:0]      addr = '0;
   logic [7:0]      wdata = '0;
   logic [7:0]      rdata;
   logic [CH-1:0]   en_o;
   logic [CH-1:0]   ld_o;
   logic [CH*VW-1:0] val_o;
   logic [CH-1:0]   int_i;
   logic            irq;

   logic [CH-1:0]   tb_int = '0;
   logic            cnt_int;
   logic [7:0]      cnt;

   int n_cmp = 0;
   int n_err = 0;

   assign int_i = tb_int | {{(CH-1){1'b0}}, cnt_int};

   cnt_ctrl #(.CH(CH), .VW(VW)) dut (
      .clk   (clk),
      .xrst  (xrst),
      .wr    (wr),
      .rd    (rd),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .en_o  (en_o),
      .ld_o  (ld_o),
      .val_o (val_o),
      .int_i (int_i),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Counter channel 0: restarts on ld, counts 0..val while enabled and
   // raises int for one cycle when it reaches val (period val+1).
   always @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         cnt <= 8'd0; cnt_int <= 1'b0;
      end else if (ld_o[0]) begin
         cnt <= 8'd0; cnt_int <= 1'b0;
      end else if (en_o[0]) begin
         if (cnt == val_o[7:0]) begin
            cnt <= 8'd0; cnt_int <= 1'b1;
         end else begin
            cnt <= cnt + 8'd1; cnt_int <= 1'b0;
         end
      end else begin
         cnt_int <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   logic [7:0] m_ctrl, m_stat, m_mask, m_ovr, m_ld, m_rdata;
   logic       m_irq;
   logic [7:0] m_val [8];
   logic [7:0] m_nstat, m_novr, m_clr_s, m_clr_o, m_ints;

   function automatic logic [7:0] m_read(input logic [3:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return m_ctrl;
      if (ai == 1) return m_stat;
      if (ai == 2) return m_mask;
      if (ai == 3) return m_ovr;
      if (ai >= 4 && ai < 4 + CH) return m_val[ai-4];
      return 8'h00;
   endfunction

   always @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         m_ctrl = 0; m_stat = 0; m_mask = 0; m_ovr = 0; m_ld = 0;
         m_rdata = 0; m_irq = 0;
         for (int i = 0; i < 8; i++) m_val[i] = 0;
      end else begin
         if (rd) m_rdata = m_read(addr);
         m_irq   = |(m_stat & m_mask);
         m_ints  = {{(8-CH){1'b0}}, int_i};
         m_clr_s = (wr && addr == 4'd1) ? (wdata & CHM) : 8'h00;
         m_clr_o = (wr && addr == 4'd3) ? (wdata & CHM) : 8'h00;
         for (int i = 0; i < CH; i++) begin
            // pending int + new int, not acknowledged now -> overrun
            if (m_ints[i] && m_stat[i] && !m_clr_s[i]) m_novr[i] = 1'b1;
            else if (m_clr_o[i])                     m_novr[i] = 1'b0;
            else                                     m_novr[i] = m_ovr[i];
            if (m_ints[i])       m_nstat[i] = 1'b1;
            else if (m_clr_s[i]) m_nstat[i] = 1'b0;
            else                 m_nstat[i] = m_stat[i];
         end
         for (int i = CH; i < 8; i++) begin
            m_nstat[i] = 1'b0; m_novr[i] = 1'b0;
         end
         m_stat = m_nstat;
         m_ovr  = m_novr;
         m_ld   = 0;
         if (wr) begin
            if (addr == 4'd0) m_ctrl = wdata & CHM;
            if (addr == 4'd2) m_mask = wdata & CHM;
            if (int'(addr) >= 4 && int'(addr) < 4 + CH) begin
               m_val[int'(addr)-4] = wdata;
               m_ld[int'(addr)-4]  = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   logic [31:0] exp_val;
   always @(negedge clk) begin
      for (int i = 0; i < CH; i++) exp_val[i*8 +: 8] = m_val[i];
      chk("cyc_en_o",  32'(en_o),  32'(m_ctrl & CHM));
      chk("cyc_ld_o",  32'(ld_o),  32'(m_ld & CHM));
      chk("cyc_val_o", 32'(val_o), exp_val);
      chk("cyc_rdata", 32'(rdata), 32'(m_rdata));
      chk("cyc_irq",   32'(irq),   32'(m_irq));
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk); wr = 1'b1; addr = a; wdata = d;
      @(negedge clk); wr = 1'b0;
   endtask

   task automatic read_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
      @(negedge clk); rd = 1'b1; addr = a;
      @(negedge clk); rd = 1'b0;
      chk(nm, 32'(rdata), 32'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_int(input logic [CH-1:0] v);
      @(negedge clk); tb_int = v;
      @(negedge clk); tb_int = '0;
   endtask

   initial begin
      idle(3);
      xrst = 1'b1;

      // 1. reset state
      chk("rst_en", 32'(en_o), 0);
      chk("rst_ld", 32'(ld_o), 0);
      chk("rst_val", 32'(val_o), 0);
      chk("rst_irq", 32'(irq), 0);
      for (int a = 0; a < 8; a++) read_chk("rst_read", 4'(a), 8'h00);

      // 2. load pulse and readback
      write_reg(4'h5, 8'h03);
      chk("ld_pulse", 32'(ld_o), 32'h2);
      chk("val1", 32'(val_o[15:8]), 32'h03);
      @(negedge clk);
      chk("ld_one_cycle", 32'(ld_o), 0);
      read_chk("rd_val1", 4'h5, 8'h03);

      // back-to-back writes: VAL_2 twice then VAL_3
      @(negedge clk); wr = 1'b1; addr = 4'h6; wdata = 8'h11;
      @(negedge clk); wdata = 8'h22;
      chk("b2b_ld_a", 32'(ld_o), 32'h4);
      chk("b2b_val_a", 32'(val_o[23:16]), 32'h11);
      @(negedge clk); addr = 4'h7; wdata = 8'h33;
      chk("b2b_ld_b", 32'(ld_o), 32'h4);
      chk("b2b_val_b", 32'(val_o[23:16]), 32'h22);
      @(negedge clk); wr = 1'b0;
      chk("b2b_ld_c", 32'(ld_o), 32'h8);
      @(negedge clk);
      chk("b2b_ld_end", 32'(ld_o), 0);

      // unmapped addresses
      write_reg(4'hA, 8'h5A);
      chk("unmap_ld", 32'(ld_o), 0);
      read_chk("unmap_rdA", 4'hA, 8'h00);
      read_chk("unmap_rd8", 4'h8, 8'h00);

      // upper bits ignored; simultaneous wr+rd returns pre-write value
      write_reg(4'h2, 8'hF0);
      read_chk("mask_hi", 4'h2, 8'h00);
      write_reg(4'h0, 8'h0E);
      @(negedge clk); wr = 1'b1; rd = 1'b1; addr = 4'h0; wdata = 8'h06;
      @(negedge clk); wr = 1'b0; rd = 1'b0;
      chk("wr_rd_pre", 32'(rdata), 32'h0E);
      chk("wr_rd_en", 32'(en_o), 32'h6);
      write_reg(4'h0, 8'h00);

      // 3. status and irq
      write_reg(4'h2, 8'h01);
      pulse_int(4'b0001);
      chk("irq_lag", 32'(irq), 0);
      @(negedge clk);
      chk("irq_set", 32'(irq), 1);
      read_chk("stat_set", 4'h1, 8'h01);
      write_reg(4'h1, 8'h01);
      read_chk("stat_clr", 4'h1, 8'h00);
      chk("irq_clr", 32'(irq), 0);
      write_reg(4'h2, 8'h00);
      pulse_int(4'b0001);
      idle(2);
      chk("irq_masked", 32'(irq), 0);
      read_chk("stat_masked", 4'h1, 8'h01);
      write_reg(4'h1, 8'h01);

      // 4. set wins over clear
      pulse_int(4'b0100);
      @(negedge clk); tb_int = 4'b0100; wr = 1'b1; addr = 4'h1; wdata = 8'h04;
      @(negedge clk); tb_int = '0; wr = 1'b0;
      read_chk("race_stat", 4'h1, 8'h04);
      read_chk("race_ovr", 4'h3, 8'h00);

      // 5. overrun
      pulse_int(4'b1000);
      pulse_int(4'b1000);
      read_chk("ovr_stat", 4'h1, 8'h0C);
      read_chk("ovr_set", 4'h3, 8'h08);
      write_reg(4'h3, 8'h08);
      read_chk("ovr_clr", 4'h3, 8'h00);
      read_chk("ovr_stat_keep", 4'h1, 8'h0C);
      @(negedge clk); tb_int = 4'b1000;
      write_reg(4'h1, 8'h08);
      idle(2);
      read_chk("hold_stat", 4'h1, 8'h0C);
      write_reg(4'h3, 8'h08);
      idle(2);
      read_chk("hold_ovr", 4'h3, 8'h08);
      tb_int = '0;
      write_reg(4'h1, 8'hFF);
      write_reg(4'h3, 8'hFF);
      read_chk("clean_stat", 4'h1, 8'h00);
      read_chk("clean_ovr", 4'h3, 8'h00);

      // 6. end to end with counter channel 0
      write_reg(4'h4, 8'h02);
      write_reg(4'h0, 8'h01);
      idle(12);
      read_chk("e2e_ovr", 4'h3, 8'h01);
      read_chk("e2e_stat", 4'h1, 8'h01);
      write_reg(4'h0, 8'h00);
      chk("e2e_en_off", 32'(en_o), 0);
      idle(2);
      write_reg(4'h1, 8'hFF);
      write_reg(4'h3, 8'hFF);
      idle(6);
      read_chk("e2e_stopped", 4'h1, 8'h00);
      read_chk("e2e_ovr_off", 4'h3, 8'h00);

      // asynchronous reset mid-operation
      write_reg(4'h2, 8'h01);
      write_reg(4'h0, 8'h01);
      idle(8);
      chk("pre_rst_irq", 32'(irq), 1);
      read_chk("pre_rst_val", 4'h4, 8'h02);
      @(posedge clk); #2;
      xrst = 1'b0;
      #1;
      chk("arst_en", 32'(en_o), 0);
      chk("arst_ld", 32'(ld_o), 0);
      chk("arst_val", 32'(val_o), 0);
      chk("arst_irq", 32'(irq), 0);
      chk("arst_rdata", 32'(rdata), 0);
      idle(2);
      xrst = 1'b1;
      read_chk("post_rst_ctrl", 4'h0, 8'h00);
      read_chk("post_rst_val", 4'h4, 8'h00);
      read_chk("post_rst_mask", 4'h2, 8'h00);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
